pkt_filter: RTL
===============

PKT_FILTER -- requirements
Module: pkt_filter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset: clk_i, rst_i.
REQ-002 Parameter DATA_WIDTH SHALL default to 8 and SHALL set the byte width of both streams; only 8 is supported.
REQ-003 Parameter CNT_WIDTH SHALL default to 16 and SHALL set the width of the two statistics counters.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk_i, in, 1: clock.
- rst_i, in, 1: async reset, active-high.
- s_tdata, in, 8: byte from the UART receiver.
- s_tvalid, in, 1: s_tdata is valid.
- s_tready, out, 1: block accepts the byte this cycle.
- m_tdata, out, 8: byte sent to the ALU.
- m_tvalid, out, 1: m_tdata is valid.
- m_tready, in, 1: ALU accepts the byte this cycle.
- err_o, out, 1: one-cycle pulse on every dropped packet or byte.
- ok_cnt_o, out, CNT_WIDTH: count of forwarded packets, saturating.
- drop_cnt_o, out, CNT_WIDTH: count of dropped packets, saturating.

Function
REQ-005 Packet format SHALL be: opcode, reserved byte, length LSB, length MSB, then payload. LEN is the 16-bit total packet length, header included.
REQ-006 Valid opcodes SHALL be 0xEC (echo), 0xAD (add), 0xAF (mul) and 0xF6 (div).
REQ-007 A byte transfers on s when s_tvalid and s_tready are both high, and on m when m_tvalid and m_tready are both high.
REQ-008 States SHALL be IDLE, HDR, CHECK, FWD_HDR, FWD_PAY and DROP.
REQ-009 IDLE: s_tready=1. A valid opcode SHALL be stored in hdr[0], idx set to 1, next state HDR. An invalid opcode SHALL be discarded, pulse err_o, increment drop_cnt_o, and stay in IDLE.
REQ-010 HDR: s_tready=1. Each transfer SHALL store the byte in hdr[idx] and increment idx. The transfer with idx=3 SHALL go to CHECK.
REQ-011 CHECK: one cycle, s_tready=0. The header is accepted when LEN>=4 for echo, or when LEN>=12 and LEN[1:0]==0 for add/mul/div. Accepted goes to FWD_HDR with idx=0; rejected goes to DROP.
REQ-012 FWD_HDR: s_tready=0, m_tvalid=1, m_tdata=hdr[idx]. idx SHALL advance only on an m transfer. The transfer of hdr[3] SHALL go to FWD_PAY with rem=LEN-4, or to IDLE when rem would be 0.
REQ-013 FWD_PAY: combinational pass-through, with m_tdata=s_tdata, m_tvalid=s_tvalid and s_tready=m_tready. Each transfer SHALL decrement rem. The transfer at rem=1 SHALL go to IDLE.
REQ-014 Every packet forwarded to completion SHALL increment ok_cnt_o once, on its final m transfer.
REQ-015 DROP: s_tready=1, m_tvalid=0. On entry: err_o pulses, drop_cnt_o increments, rem=LEN-4 (0 if LEN<4). Each s transfer SHALL decrement rem. Exit to IDLE SHALL occur when rem reaches 0, or on the entry cycle itself if rem=0.
REQ-016 m_tvalid SHALL never drop, and m_tdata SHALL never change, while m_tvalid=1 and m_tready=0, in FWD_HDR.
REQ-017 The block SHALL be bubble-free: latency in FWD_PAY is 0 cycles. Header latency is 4 s transfers, plus 1 CHECK cycle, plus 4 m transfers.
REQ-018 Counters SHALL saturate at all-ones and never wrap.
REQ-019 The rem and LEN arithmetic SHALL be 16-bit unsigned. LEN=0xFFFF SHALL be handled without overflow.
REQ-020 s_tready and m_tvalid SHALL each be 0 in any state not listed for them above.

Reset
REQ-021 Asserting rst_i SHALL immediately force, with no clock edge needed: state=IDLE, idx=0, rem=0, hdr=0, err_o=0, ok_cnt_o=0, drop_cnt_o=0, m_tvalid=0.
REQ-022 After reset, s_tready SHALL be 1 from the first cycle.
REQ-023 Reset asserted mid-packet SHALL abandon the packet without counting it.
REQ-024 Bytes arriving after reset release SHALL be parsed as a new opcode.

Verification
REQ-025 Echo pass: send EC 00 06 00 41 42 with m_tready=1. m SHALL carry EC 00 06 00 41 42, ok_cnt=1, err_o never high.
REQ-026 Bad opcode: send 55 then AD 00 0C 00 + 8 payload bytes. The 55 SHALL be dropped (err pulse, drop_cnt=1), then the add packet forwarded intact (ok_cnt=1).
REQ-027 Bad length: send AF 00 0A 00 + 6 bytes, then EC 00 04 00. The first packet SHALL be dropped (drop_cnt=1, nothing on m), then EC 00 04 00 forwarded (ok_cnt=1).
REQ-028 Backpressure: send F6 00 0C 00 + 8 bytes with m_tready toggling every cycle. All 12 bytes SHALL arrive in order, m_tdata SHALL be stable while stalled, and s_tready=0 during FWD_HDR.
REQ-029 Reset mid-packet: assert rst_i after the byte 0x11 of AD 00 0C 00 11, without a clock edge. Outputs SHALL clear asynchronously. A following EC 00 04 00 SHALL forward normally with ok_cnt=1.
REQ-030 Saturation: with CNT_WIDTH=2, send 5 bad opcodes. drop_cnt_o SHALL read 3 and stay at 3.

Source files
------------

// File: rtl/pkt_filter.sv
// pkt_filter: header check and forward/drop filter between a UART receiver
// byte stream (s_*) and an ALU byte stream (m_*).
//
// Packet layout: opcode, reserved, LEN lsb, LEN msb, payload. LEN counts the
// whole packet including the 4 header bytes. The header is buffered, checked
// for a legal opcode/length combination, then either replayed on m followed
// by a zero-latency payload pass-through, or swallowed.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready  input byte stream
//   m_tdata/m_tvalid/m_tready  output byte stream
//   err_o                 one-cycle pulse per dropped packet or opcode byte
//   ok_cnt_o              saturating count of fully forwarded packets
//   drop_cnt_o            saturating count of dropped packets/opcodes
module pkt_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  ok_cnt_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAF;
  localparam logic [7:0] OP_DIV  = 8'hF6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    CHECK   = 3'd2,
    FWD_HDR = 3'd3,
    FWD_PAY = 3'd4,
    DROP    = 3'd5
  } state_t;

  state_t                   state_r, state_s;
  logic [1:0]               idx_r, idx_s;
  logic [15:0]              rem_r, rem_s;
  logic [3:0][7:0]          hdr_r, hdr_s;
  logic                     err_s;
  logic [CNT_WIDTH-1:0]     ok_cnt_s, drop_cnt_s;
  logic [15:0]              len_s;
  logic                     hdr_ok_s;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    sat_inc = (&v) ? v : v + one;
  endfunction

  // True for the four opcodes the ALU understands.
  function automatic logic is_opcode(input logic [7:0] b);
    case (b)
      OP_ECHO, OP_ADD, OP_MUL, OP_DIV: is_opcode = 1'b1;
      default:                         is_opcode = 1'b0;
    endcase
  endfunction

  // Length field and acceptance rule: echo needs only a full header, the
  // arithmetic ops need at least two 32-bit operands and word alignment.
  always_comb begin
    len_s = {hdr_r[3], hdr_r[2]};
    if (hdr_r[0] == OP_ECHO) begin
      hdr_ok_s = (len_s >= 16'd4);
    end else begin
      hdr_ok_s = (len_s >= 16'd12) && (len_s[1:0] == 2'b00);
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    rem_s      = rem_r;
    hdr_s      = hdr_r;
    err_s      = 1'b0;
    ok_cnt_s   = ok_cnt_o;
    drop_cnt_s = drop_cnt_o;
    s_tready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    case (state_r)
      IDLE: begin
        s_tready = 1'b1;
        if (s_tvalid && is_opcode(s_tdata)) begin
          hdr_s[0] = s_tdata;
          idx_s    = 2'd1;
          state_s  = HDR;
        end else if (s_tvalid) begin
          err_s      = 1'b1;
          drop_cnt_s = sat_inc(drop_cnt_o);
        end else begin
          state_s = IDLE;
        end
      end
      HDR: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          hdr_s[idx_r] = s_tdata;
          idx_s        = idx_r + 2'd1;
          state_s      = (idx_r == 2'd3) ? CHECK : HDR;
        end else begin
          state_s = HDR;
        end
      end
      CHECK: begin
        // rem is loaded here for both outcomes; LEN<4 can only be rejected,
        // so the clamp to zero never hides a forwarded byte.
        idx_s = 2'd0;
        rem_s = (len_s >= 16'd4) ? (len_s - 16'd4) : 16'd0;
        if (hdr_ok_s) begin
          state_s = FWD_HDR;
        end else begin
          state_s    = DROP;
          err_s      = 1'b1;
          drop_cnt_s = sat_inc(drop_cnt_o);
        end
      end
      FWD_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_r[idx_r];
        if (m_tready && (idx_r == 2'd3)) begin
          idx_s = 2'd0;
          if (rem_r == 16'd0) begin
            state_s  = IDLE;
            ok_cnt_s = sat_inc(ok_cnt_o);
          end else begin
            state_s = FWD_PAY;
          end
        end else if (m_tready) begin
          idx_s = idx_r + 2'd1;
        end else begin
          idx_s = idx_r;
        end
      end
      FWD_PAY: begin
        m_tdata  = s_tdata;
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        if (s_tvalid && m_tready) begin
          rem_s = rem_r - 16'd1;
          if (rem_r == 16'd1) begin
            state_s  = IDLE;
            ok_cnt_s = sat_inc(ok_cnt_o);
          end else begin
            state_s = FWD_PAY;
          end
        end else begin
          rem_s = rem_r;
        end
      end
      DROP: begin
        // With nothing left to swallow, refuse the byte so the next opcode
        // is not eaten on the way out.
        s_tready = (rem_r != 16'd0);
        if (rem_r == 16'd0) begin
          state_s = IDLE;
        end else if (s_tvalid) begin
          rem_s   = rem_r - 16'd1;
          state_s = (rem_r == 16'd1) ? IDLE : DROP;
        end else begin
          rem_s = rem_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 2'd0;
        rem_s   = 16'd0;
      end
    endcase
  end

  // State, header buffer, counters and error pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      idx_r      <= 2'd0;
      rem_r      <= 16'd0;
      hdr_r      <= '0;
      err_o      <= 1'b0;
      ok_cnt_o   <= '0;
      drop_cnt_o <= '0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      rem_r      <= rem_s;
      hdr_r      <= hdr_s;
      err_o      <= err_s;
      ok_cnt_o   <= ok_cnt_s;
      drop_cnt_o <= drop_cnt_s;
    end
  end

endmodule
